// File: rtl/bcd_alarm_counter_mux_pkg.sv
// Shared types and 7-segment encoding for the BCD alarm counter and its display scan.
package bcd_alarm_counter_mux_pkg;

    localparam int unsigned BCD_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef logic [BCD_W-1:0] bcd_t;
    typedef logic [SEG_W-1:0] seg_t;

    // Segment order {g,f,e,d,c,b,a}, active high
    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1100111;
    localparam seg_t SEG_BLANK = 7'b0000000;

    function automatic seg_t bcd_to_seg(input bcd_t d);
        seg_t s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic bcd_valid(input bcd_t d);
        return (d <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_alarm_counter_mux_if.sv
// Switch/button inputs and display/speaker outputs of the BCD alarm counter.
interface bcd_alarm_counter_mux_if #(
    parameter int unsigned NDIG = 4
);
    logic              en;
    logic              dir;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic [4*NDIG-1:0] alarm_val;
    logic              alarm_clr;
    logic [4*NDIG-1:0] count;
    logic              sp;
    logic [6:0]        o;
    logic [NDIG-1:0]   com;

    modport master (
        output en, dir, load, load_val, alarm_val, alarm_clr,
        input  count, sp, o, com
    );

    modport slave (
        input  en, dir, load, load_val, alarm_val, alarm_clr,
        output count, sp, o, com
    );
endinterface

// File: rtl/bcd_alarm_counter_mux_seg7_scan_mux.sv
// Time-multiplexed 7-segment scan: walks digit index every SCAN_DIV clocks, updating o and com together.
module seg7_scan_mux
    import bcd_alarm_counter_mux_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned SCAN_DIV = 4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] count,
    output logic [6:0]        o,
    output logic [NDIG-1:0]   com
);

    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    logic [SW-1:0]   scnt_q, scnt_d;
    logic [IW-1:0]   idx_q, idx_d;
    seg_t            o_q, o_d;
    logic [NDIG-1:0] com_q, com_d;
    bcd_t            digs [NDIG];
    logic            wrap_c;

    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            digs[i] = count[4*i +: 4];
        end
    end

    // Next index is computed first so segments always match the newly selected digit
    always_comb begin
        scnt_d = scnt_q + SW'(1);
        idx_d  = idx_q;
        o_d    = o_q;
        com_d  = com_q;
        wrap_c = (scnt_q == SW'(SCAN_DIV - 1));
        if (wrap_c) begin
            scnt_d = '0;
            idx_d  = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + IW'(1);
            com_d  = NDIG'(1) << idx_d;
            o_d    = bcd_to_seg(digs[idx_d]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scnt_q <= '0;
            idx_q  <= '0;
            o_q    <= SEG_0;
            com_q  <= NDIG'(1);
        end else begin
            scnt_q <= scnt_d;
            idx_q  <= idx_d;
            o_q    <= o_d;
            com_q  <= com_d;
        end
    end

    assign o   = o_q;
    assign com = com_q;

endmodule

// File: rtl/bcd_alarm_counter_mux.sv
// N-digit BCD up/down counter with prescaled tick, preset load, sticky alarm and scanned 7-segment output.
module bcd_alarm_counter_mux
    import bcd_alarm_counter_mux_pkg::*;
#(
    parameter int unsigned NDIG     = 4,
    parameter int unsigned TICK_DIV = 2500000,
    parameter int unsigned SCAN_DIV = 4000
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_alarm_counter_mux_if.slave bus
);

    localparam int unsigned CW = 4 * NDIG;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          sp_q, sp_d;
    logic [CW-1:0] cnt_inc, cnt_dec, load_clean;
    logic          tick_c;
    logic          write_c;
    logic          alarm_ok_c;
    logic          carry, borrow;
    bcd_t          d_up, d_dn, d_ld, d_al;

    assign tick_c = (presc_q == PW'(TICK_DIV - 1));

    // Ripple BCD increment/decrement; digits are always valid so 9/0 are the only wrap points
    always_comb begin
        cnt_inc    = count_q;
        cnt_dec    = count_q;
        load_clean = '0;
        alarm_ok_c = 1'b1;
        carry      = 1'b1;
        borrow     = 1'b1;
        d_up       = '0;
        d_dn       = '0;
        d_ld       = '0;
        d_al       = '0;
        for (int i = 0; i < NDIG; i++) begin
            d_up = count_q[4*i +: 4];
            if (carry) begin
                if (d_up >= 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = d_up + 4'd1;
                    carry             = 1'b0;
                end
            end
            d_dn = count_q[4*i +: 4];
            if (borrow) begin
                if (d_dn == 4'd0) begin
                    cnt_dec[4*i +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*i +: 4] = d_dn - 4'd1;
                    borrow            = 1'b0;
                end
            end
            d_ld = bus.load_val[4*i +: 4];
            load_clean[4*i +: 4] = bcd_valid(d_ld) ? d_ld : 4'd0;
            d_al = bus.alarm_val[4*i +: 4];
            if (!bcd_valid(d_al)) begin
                alarm_ok_c = 1'b0;
            end
        end
    end

    // Priority: en low > load > tick; alarm set overrides a same-edge clear
    always_comb begin
        count_d = count_q;
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        sp_d    = sp_q;
        write_c = 1'b0;
        if (!bus.en) begin
            count_d = '0;
            presc_d = '0;
            sp_d    = 1'b0;
        end else begin
            if (bus.load) begin
                count_d = load_clean;
                presc_d = '0;
                write_c = 1'b1;
            end else if (tick_c) begin
                count_d = bus.dir ? cnt_dec : cnt_inc;
                write_c = 1'b1;
            end
            if (bus.alarm_clr) begin
                sp_d = 1'b0;
            end
            if (write_c && alarm_ok_c && (count_d == bus.alarm_val)) begin
                sp_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            presc_q <= '0;
            sp_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            sp_q    <= sp_d;
        end
    end

    seg7_scan_mux #(
        .NDIG     (NDIG),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk   (clk),
        .rst   (rst),
        .count (count_q),
        .o     (bus.o),
        .com   (bus.com)
    );

    assign bus.count = count_q;
    assign bus.sp    = sp_q;

endmodule

// File: tb/tb_bcd_alarm_counter_mux.sv
// Directed bench for bcd_alarm_counter_mux with NDIG=2, TICK_DIV=4, SCAN_DIV=3.
module tb_bcd_alarm_counter_mux;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    bcd_alarm_counter_mux_if #(.NDIG(2)) bus ();

    bcd_alarm_counter_mux #(
        .NDIG     (2),
        .TICK_DIV (4),
        .SCAN_DIV (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clock edges, landing 1 time unit after the last one
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_chk         = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.dir       = 1'b0;
        bus.load      = 1'b0;
        bus.load_val  = 8'h00;
        bus.alarm_val = 8'hFF;
        bus.alarm_clr = 1'b0;

        step(2);
        chk("rst_count", 32'(bus.count), 32'h00);
        chk("rst_sp",    32'(bus.sp),    32'h0);
        chk("rst_com",   32'(bus.com),   32'h1);
        chk("rst_o",     32'(bus.o),     32'h3F);

        // Up count from reset
        rst    = 1'b0;
        bus.en = 1'b1;
        step(3);
        chk("up_hold3", 32'(bus.count), 32'h00);
        step(1);
        chk("up_first", 32'(bus.count), 32'h01);
        step(4);
        chk("up_02", 32'(bus.count), 32'h02);
        step(28);
        chk("up_09", 32'(bus.count), 32'h09);
        step(4);
        chk("up_10", 32'(bus.count), 32'h10);

        // 99 -> 00 wrap via preset 98
        bus.load     = 1'b1;
        bus.load_val = 8'h98;
        step(1);
        bus.load = 1'b0;
        chk("load_98", 32'(bus.count), 32'h98);
        step(4);
        chk("up_99", 32'(bus.count), 32'h99);
        step(4);
        chk("up_wrap", 32'(bus.count), 32'h00);

        // Down count from 05 through 00 to 99
        bus.alarm_val = 8'h50;
        bus.dir       = 1'b1;
        bus.load      = 1'b1;
        bus.load_val  = 8'h05;
        step(1);
        bus.load = 1'b0;
        chk("load_05", 32'(bus.count), 32'h05);
        step(4);
        chk("dn_04", 32'(bus.count), 32'h04);
        step(16);
        chk("dn_00", 32'(bus.count), 32'h00);
        chk("dn_sp0", 32'(bus.sp), 32'h0);
        step(4);
        chk("dn_wrap", 32'(bus.count), 32'h99);
        chk("dn_sp_wrap", 32'(bus.sp), 32'h0);

        // Alarm at 12 counting up from 10
        bus.dir       = 1'b0;
        bus.alarm_val = 8'h12;
        bus.load      = 1'b1;
        bus.load_val  = 8'h10;
        step(1);
        bus.load = 1'b0;
        chk("al_load10", 32'(bus.count), 32'h10);
        step(7);
        chk("al_11", 32'(bus.count), 32'h11);
        chk("al_11_sp", 32'(bus.sp), 32'h0);
        step(1);
        chk("al_12", 32'(bus.count), 32'h12);
        chk("al_12_sp", 32'(bus.sp), 32'h1);
        bus.alarm_clr = 1'b1;
        step(1);
        bus.alarm_clr = 1'b0;
        chk("al_clr_sp", 32'(bus.sp), 32'h0);
        chk("al_clr_cnt", 32'(bus.count), 32'h12);
        step(3);
        chk("al_13", 32'(bus.count), 32'h13);
        chk("al_13_sp", 32'(bus.sp), 32'h0);
        step(395);
        chk("al_pass_11", 32'(bus.count), 32'h11);
        chk("al_pass_11_sp", 32'(bus.sp), 32'h0);
        step(1);
        chk("al_pass_12", 32'(bus.count), 32'h12);
        chk("al_pass_12_sp", 32'(bus.sp), 32'h1);

        // Clear coinciding with alarm event: set wins
        bus.alarm_clr = 1'b1;
        step(1);
        bus.alarm_clr = 1'b0;
        chk("co_pre_sp", 32'(bus.sp), 32'h0);
        bus.load     = 1'b1;
        bus.load_val = 8'h11;
        step(1);
        bus.load = 1'b0;
        chk("co_load11", 32'(bus.count), 32'h11);
        step(3);
        bus.alarm_clr = 1'b1;
        step(1);
        bus.alarm_clr = 1'b0;
        chk("co_12", 32'(bus.count), 32'h12);
        chk("co_sp", 32'(bus.sp), 32'h1);

        // Load equal to alarm value sets sp immediately
        bus.alarm_clr = 1'b1;
        step(1);
        bus.alarm_clr = 1'b0;
        chk("ld_pre_sp", 32'(bus.sp), 32'h0);
        bus.load     = 1'b1;
        bus.load_val = 8'h12;
        step(1);
        bus.load = 1'b0;
        chk("ld12_cnt", 32'(bus.count), 32'h12);
        chk("ld12_sp", 32'(bus.sp), 32'h1);

        // Invalid digit preset, then en drop mid-count
        bus.load     = 1'b1;
        bus.load_val = 8'h3A;
        step(1);
        bus.load = 1'b0;
        chk("ld3a_cnt", 32'(bus.count), 32'h30);
        chk("ld3a_sp", 32'(bus.sp), 32'h1);
        step(2);
        bus.en       = 1'b0;
        bus.load     = 1'b1;
        bus.load_val = 8'h55;
        step(1);
        chk("en0_cnt", 32'(bus.count), 32'h00);
        chk("en0_sp", 32'(bus.sp), 32'h0);
        step(1);
        chk("en0_noload", 32'(bus.count), 32'h00);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step(3);
        chk("en1_hold", 32'(bus.count), 32'h00);
        step(1);
        chk("en1_first", 32'(bus.count), 32'h01);

        // Scan with count held at 47 by a continuous load, phase aligned by reset
        bus.alarm_val = 8'hFF;
        bus.load      = 1'b1;
        bus.load_val  = 8'h47;
        rst           = 1'b1;
        step(1);
        rst = 1'b0;
        chk("sc_rst_com", 32'(bus.com), 32'h1);
        step(3);
        chk("sc_cnt", 32'(bus.count), 32'h47);
        chk("sc_com_a", 32'(bus.com), 32'h2);
        chk("sc_o_a", 32'(bus.o), 32'h66);
        step(2);
        chk("sc_com_hold", 32'(bus.com), 32'h2);
        chk("sc_o_hold", 32'(bus.o), 32'h66);
        step(1);
        chk("sc_com_b", 32'(bus.com), 32'h1);
        chk("sc_o_b", 32'(bus.o), 32'h07);
        step(3);
        chk("sc_com_c", 32'(bus.com), 32'h2);
        chk("sc_o_c", 32'(bus.o), 32'h66);

        // Reset mid-scan
        step(1);
        rst = 1'b1;
        step(1);
        chk("sc_mid_com", 32'(bus.com), 32'h1);
        chk("sc_mid_o", 32'(bus.o), 32'h3F);
        chk("sc_mid_cnt", 32'(bus.count), 32'h00);
        rst = 1'b0;
        step(2);
        chk("sc_re_com_hold", 32'(bus.com), 32'h1);
        step(1);
        chk("sc_re_com", 32'(bus.com), 32'h2);
        chk("sc_re_o", 32'(bus.o), 32'h66);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
